// File: rtl/ysyx_22050598_core_ctrl_pkg.sv
// Shared encodings for the multi-cycle core sequencer.
// State codes, reset PC default and halt-cause values.
package ysyx_22050598_core_ctrl_pkg;

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_WAIT_INST = 3'd1;
  localparam logic [2:0] ST_EXEC      = 3'd2;
  localparam logic [2:0] ST_MEM_REQ   = 3'd3;
  localparam logic [2:0] ST_MEM_WAIT  = 3'd4;
  localparam logic [2:0] ST_HALT      = 3'd5;

  localparam logic [63:0] DEF_RESET_PC =
    64'h0000_0000_8000_0000;

  localparam logic HC_EBREAK = 1'b0;
  localparam logic HC_FAULT  = 1'b1;

  typedef enum logic [2:0] {
    S_FETCH     = ST_FETCH,
    S_WAIT_INST = ST_WAIT_INST,
    S_EXEC      = ST_EXEC,
    S_MEM_REQ   = ST_MEM_REQ,
    S_MEM_WAIT  = ST_MEM_WAIT,
    S_HALT      = ST_HALT
  } state_e;

endpackage

// File: rtl/ysyx_22050598_core_ctrl_if.sv
// Fetch, decode/execute and load/store signals seen by the sequencer.
// master = sequencer side, slave = bus/decoder side.
interface ysyx_22050598_core_ctrl_if;

  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic        inst_latch_en;
  logic        is_load;
  logic        is_store;
  logic        exu_wen;
  logic        j_flag;
  logic [63:0] j_pc;
  logic        ebreak_flag;
  logic        ls_req_valid;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic        rf_wen;

  modport master (
    output if_req_valid,
    output if_addr,
    output if_rsp_ready,
    output inst_latch_en,
    output ls_req_valid,
    output rf_wen,
    input  if_req_ready,
    input  if_rsp_valid,
    input  is_load,
    input  is_store,
    input  exu_wen,
    input  j_flag,
    input  j_pc,
    input  ebreak_flag,
    input  ls_req_ready,
    input  ls_rsp_valid
  );

  modport slave (
    input  if_req_valid,
    input  if_addr,
    input  if_rsp_ready,
    input  inst_latch_en,
    input  ls_req_valid,
    input  rf_wen,
    output if_req_ready,
    output if_rsp_valid,
    output is_load,
    output is_store,
    output exu_wen,
    output j_flag,
    output j_pc,
    output ebreak_flag,
    output ls_req_ready,
    output ls_rsp_valid
  );

endinterface

// File: rtl/ysyx_22050598_core_ctrl_watchdog.sv
// Per-state wait counter; expires on the TIMEOUT_CYCLES-th
// enabled cycle since the last clear.
module ysyx_22050598_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  assign expire = en && (cnt == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LIMIT) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ysyx_22050598_core_ctrl.sv
// Multi-cycle RV64 sequencer: PC owner, fetch/exec/mem/writeback
// stepping, halt handling and cycle/instret counters.
module ysyx_22050598_core_ctrl
  import ysyx_22050598_core_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC       = DEF_RESET_PC,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          CNT_W          = 64
) (
  input  logic             clk,
  input  logic             rst,
  ysyx_22050598_core_ctrl_if.master bus,
  output logic [63:0]      pc,
  output logic             halt,
  output logic             halt_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  state_e          state_q, state_d;
  logic [63:0]     pc_q, pc_d;
  logic            cause_q, cause_d;
  logic [CNT_W-1:0] cyc_q, ret_q;
  logic            retire;
  logic            wd_en, wd_clr, wd_exp;

  logic            req_if, rsp_if, latch;
  logic            req_ls, wen;

  logic            ex_brk, ex_jerr, ex_mem, ex_alu;
  logic [63:0]     pc_inc;

  assign pc_inc = pc_q + 64'd4;

  // One-hot view of the EXEC priority chain
  assign ex_brk  = bus.ebreak_flag;
  assign ex_jerr = !ex_brk && bus.j_flag &&
                   (bus.j_pc[1:0] != 2'b00);
  assign ex_mem  = !ex_brk && !ex_jerr &&
                   (bus.is_load || bus.is_store);
  assign ex_alu  = !(ex_brk || ex_jerr || ex_mem);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    retire  = 1'b0;
    wd_en   = 1'b0;
    req_if  = 1'b0;
    rsp_if  = 1'b0;
    latch   = 1'b0;
    req_ls  = 1'b0;
    wen     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        req_if = 1'b1;
        wd_en  = 1'b1;
        if (bus.if_req_ready) begin
          state_d = S_WAIT_INST;
        end else if (wd_exp) begin
          state_d = S_HALT;
          cause_d = HC_FAULT;
        end
      end
      S_WAIT_INST: begin
        rsp_if = 1'b1;
        wd_en  = 1'b1;
        if (bus.if_rsp_valid) begin
          latch   = 1'b1;
          state_d = S_EXEC;
        end else if (wd_exp) begin
          state_d = S_HALT;
          cause_d = HC_FAULT;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          ex_brk: begin
            state_d = S_HALT;
            cause_d = HC_EBREAK;
            retire  = 1'b1;
          end
          ex_jerr: begin
            state_d = S_HALT;
            cause_d = HC_FAULT;
          end
          ex_mem: begin
            state_d = S_MEM_REQ;
          end
          ex_alu: begin
            wen     = bus.exu_wen;
            pc_d    = bus.j_flag ? bus.j_pc : pc_inc;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: ;
        endcase
      end
      S_MEM_REQ: begin
        req_ls = 1'b1;
        wd_en  = 1'b1;
        if (bus.ls_req_ready) begin
          state_d = S_MEM_WAIT;
        end else if (wd_exp) begin
          state_d = S_HALT;
          cause_d = HC_FAULT;
        end
      end
      S_MEM_WAIT: begin
        wd_en = 1'b1;
        if (bus.ls_rsp_valid) begin
          wen     = bus.is_load;
          pc_d    = pc_inc;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (wd_exp) begin
          state_d = S_HALT;
          cause_d = HC_FAULT;
        end
      end
      S_HALT: ;
      default: begin
        state_d = S_HALT;
        cause_d = HC_FAULT;
      end
    endcase
  end

  assign wd_clr = (state_d != state_q);

  ysyx_22050598_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk   (clk),
    .rst   (rst),
    .clr   (wd_clr),
    .en    (wd_en),
    .expire(wd_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      cause_q <= HC_EBREAK;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      if (state_q != S_HALT) begin
        cyc_q <= cyc_q + CNT_W'(1);
      end
      if (retire) begin
        ret_q <= ret_q + CNT_W'(1);
      end
    end
  end

  assign bus.if_req_valid  = req_if;
  assign bus.if_addr       = pc_q;
  assign bus.if_rsp_ready  = rsp_if;
  assign bus.inst_latch_en = latch;
  assign bus.ls_req_valid  = req_ls;
  assign bus.rf_wen        = wen;

  assign pc        = pc_q;
  assign halt      = (state_q == S_HALT);
  assign halt_err  = halt && (cause_q == HC_FAULT);
  assign cycle_cnt = cyc_q;
  assign instret   = ret_q;

endmodule

// File: tb/tb_ysyx_22050598_core_ctrl.sv
// Self-checking bench for the core sequencer: directed cases
// plus a randomized instruction stream against a PC/counter model.
module tb_ysyx_22050598_core_ctrl;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam int TO = 1024;

  localparam int K_ALU  = 0;
  localparam int K_JAL  = 1;
  localparam int K_LD   = 2;
  localparam int K_ST   = 3;
  localparam int K_BRK  = 4;
  localparam int K_JBAD = 5;

  logic        clk;
  logic        rst;
  logic [63:0] pc;
  logic        halt;
  logic        halt_err;
  logic [63:0] cycle_cnt;
  logic [63:0] instret;

  ysyx_22050598_core_ctrl_if ifc ();

  ysyx_22050598_core_ctrl #(
    .RESET_PC      (RPC),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (ifc),
    .pc       (pc),
    .halt     (halt),
    .halt_err (halt_err),
    .cycle_cnt(cycle_cnt),
    .instret  (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: architectural PC, counters, halt status
  logic [63:0] m_pc;
  logic [63:0] m_ret;
  logic [63:0] m_cyc;
  logic        m_halt;
  logic        m_err;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!m_halt) m_cyc++;
    #1;
  endtask

  task automatic clr_inputs();
    ifc.if_req_ready = 1'b0;
    ifc.if_rsp_valid = 1'b0;
    ifc.is_load      = 1'b0;
    ifc.is_store     = 1'b0;
    ifc.exu_wen      = 1'b0;
    ifc.j_flag       = 1'b0;
    ifc.j_pc         = '0;
    ifc.ebreak_flag  = 1'b0;
    ifc.ls_req_ready = 1'b0;
    ifc.ls_rsp_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_pc   = RPC;
    m_ret  = '0;
    m_cyc  = '0;
    m_halt = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic end_chk();
    #1;
    chk("pc", pc, m_pc);
    chk("instret", instret, m_ret);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("halt", halt, m_halt);
    chk("halt_err", halt_err, m_err);
  endtask

  // Plays the bus/decoder side for one instruction
  task automatic run_instr(input int kind,
                           input logic [63:0] jpc,
                           input logic w,
                           input int d0, input int d1,
                           input int d2, input int d3,
                           input bit noise,
                           input bit abort);
    int n_wen;
    int exp_wen;
    bit mem;
    n_wen = 0;
    mem = (kind == K_LD) || (kind == K_ST);
    exp_wen = (kind == K_LD) ? 1 :
              ((kind == K_ALU || kind == K_JAL) ? int'(w) : 0);
    for (int i = 0; i <= d0; i++) begin
      ifc.if_req_ready = (i == d0);
      ifc.if_rsp_valid = noise & $urandom_range(0, 1);
      #1;
      chk("if_req_valid", ifc.if_req_valid, 1);
      chk("if_addr", ifc.if_addr, m_pc);
      chk("fetch_no_latch", ifc.inst_latch_en, 0);
      n_wen += int'(ifc.rf_wen);
      tick();
    end
    ifc.if_req_ready = 1'b0;
    for (int i = 0; i <= d1; i++) begin
      ifc.if_rsp_valid = (i == d1);
      #1;
      chk("if_rsp_ready", ifc.if_rsp_ready, 1);
      chk("inst_latch_en", ifc.inst_latch_en, i == d1);
      chk("wait_no_req", ifc.if_req_valid, 0);
      n_wen += int'(ifc.rf_wen);
      tick();
    end
    ifc.if_rsp_valid = 1'b0;
    ifc.is_load     = (kind == K_LD);
    ifc.is_store    = (kind == K_ST);
    ifc.exu_wen     = w;
    ifc.j_flag      = (kind == K_JAL) || (kind == K_JBAD);
    ifc.j_pc        = jpc;
    ifc.ebreak_flag = (kind == K_BRK);
    #1;
    chk("exec_rf_wen", ifc.rf_wen, mem ? 0 : exp_wen);
    chk("exec_no_req",
        ifc.if_req_valid | ifc.ls_req_valid, 0);
    chk("exec_no_latch", ifc.inst_latch_en, 0);
    n_wen += int'(ifc.rf_wen);
    tick();
    case (kind)
      K_ALU: begin m_pc = m_pc + 64'd4; m_ret++; end
      K_JAL: begin m_pc = jpc; m_ret++; end
      K_BRK: begin m_ret++; m_halt = 1; m_err = 0; end
      K_JBAD: begin m_halt = 1; m_err = 1; end
      default: ;
    endcase
    if (mem) begin
      for (int i = 0; i <= d2; i++) begin
        ifc.ls_req_ready = (i == d2);
        ifc.ls_rsp_valid = noise & $urandom_range(0, 1);
        #1;
        chk("ls_req_valid", ifc.ls_req_valid, 1);
        chk("memreq_rf_wen", ifc.rf_wen, 0);
        n_wen += int'(ifc.rf_wen);
        tick();
      end
      ifc.ls_req_ready = 1'b0;
      ifc.ls_rsp_valid = 1'b0;
      if (abort) begin
        rst = 1'b1;
        #1;
        chk("abort_pc", pc, RPC);
        chk("abort_instret", instret, 0);
        chk("abort_cycle", cycle_cnt, 0);
        chk("abort_halt", halt, 0);
        chk("abort_ls_valid", ifc.ls_req_valid, 0);
        chk("abort_if_valid", ifc.if_req_valid, 1);
        do_reset();
        return;
      end
      for (int i = 0; i <= d3; i++) begin
        ifc.ls_rsp_valid = (i == d3);
        #1;
        chk("memwait_rf_wen", ifc.rf_wen,
            (kind == K_LD) && (i == d3));
        chk("memwait_no_req", ifc.ls_req_valid, 0);
        n_wen += int'(ifc.rf_wen);
        tick();
      end
      ifc.ls_rsp_valid = 1'b0;
      m_pc = m_pc + 64'd4;
      m_ret++;
    end
    chk("rf_wen_pulses", n_wen, exp_wen);
    end_chk();
  endtask

  logic [63:0] rj;

  initial begin
    rst = 1'b0;
    clr_inputs();
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_pc", pc, RPC);
    chk("rst_instret", instret, 0);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_halt", halt, 0);
    chk("rst_halt_err", halt_err, 0);
    chk("rst_if_valid", ifc.if_req_valid, 1);
    chk("rst_ls_valid", ifc.ls_req_valid, 0);
    chk("rst_rf_wen", ifc.rf_wen, 0);
    do_reset();

    // addi: one-cycle ready everywhere
    run_instr(K_ALU, '0, 1'b1, 0, 0, 0, 0, 0, 0);
    chk("addi_pc", pc, 64'h8000_0004);
    chk("addi_instret", instret, 1);
    chk("addi_cycles", cycle_cnt, 3);
    chk("addi_back_fetch", ifc.if_req_valid, 1);

    run_instr(K_JAL, 64'h8000_0100, 1'b1,
              0, 0, 0, 0, 0, 0);
    chk("jal_pc", pc, 64'h8000_0100);

    run_instr(K_LD, '0, 1'b0, 1, 0, 3, 2, 0, 0);
    chk("load_pc", pc, 64'h8000_0104);
    run_instr(K_ST, '0, 1'b1, 0, 1, 1, 1, 0, 0);
    chk("store_pc", pc, 64'h8000_0108);

    // pc+4 wraps at the top of the address space
    run_instr(K_JAL, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0,
              0, 0, 0, 0, 0, 0);
    run_instr(K_ALU, '0, 1'b1, 0, 0, 0, 0, 0, 0);
    chk("wrap_pc", pc, 0);

    for (int n = 0; n < 40; n++) begin
      rj = {$urandom, $urandom};
      rj[1:0] = 2'b00;
      run_instr($urandom_range(0, 3), rj,
                1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                1, 0);
    end

    // async reset in the middle of a load
    run_instr(K_LD, '0, 1'b0, 0, 0, 1, 0, 0, 1);
    end_chk();

    run_instr(K_ALU, '0, 1'b1, 0, 0, 0, 0, 0, 0);
    run_instr(K_JBAD, 64'h8000_0102, 1'b1,
              0, 0, 0, 0, 0, 0);
    chk("jbad_pc", pc, 64'h8000_0004);
    chk("jbad_instret", instret, 1);
    chk("jbad_err", halt_err, 1);
    repeat (5) tick();
    chk("jbad_sticky", halt, 1);
    chk("jbad_if_valid", ifc.if_req_valid, 0);
    do_reset();

    run_instr(K_ALU, '0, 1'b0, 1, 1, 0, 0, 0, 0);
    run_instr(K_BRK, '0, 1'b1, 0, 0, 0, 0, 0, 0);
    chk("brk_err", halt_err, 0);
    chk("brk_instret", instret, 2);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("brk_cycle_frozen", cycle_cnt, m_cyc);
      chk("brk_no_req",
          ifc.if_req_valid | ifc.ls_req_valid, 0);
    end
    do_reset();

    // fetch never accepted
    repeat (TO - 1) tick();
    chk("to_not_yet", halt, 0);
    chk("to_if_valid", ifc.if_req_valid, 1);
    tick();
    m_halt = 1'b1;
    m_err  = 1'b1;
    end_chk();
    chk("to_cycles", cycle_cnt, TO);
    do_reset();
    end_chk();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
